// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared types and constants for the pattern scan controller and its matcher.
package pattern_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } scan_state_t;

  localparam int unsigned PAT_W  = 4;
  localparam int unsigned HIST_W = PAT_W - 1;

endpackage

// File: rtl/pattern_scan_ctrl_seq_match4.sv
// Programmable 4-bit Mealy sequence matcher with overlapping detection.
module seq_match4
  import pattern_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  logic [HIST_W-1:0] hist_q, hist_d;
  logic [1:0]        fill_q, fill_d;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (valid) begin
      hist_d = {hist_q[HIST_W-2:0], bit_in};
      if (fill_q != 2'd3) fill_d = fill_q + 2'd1;
    end
  end

  // fill saturates at 3, so fill_q==3 means at least three bits of history
  assign match = valid && (fill_q == 2'd3) && ({hist_q, bit_in} == pattern);

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Scan controller: shifts a captured word MSB-first through seq_match4 and counts matches.
// Optional abort input enabled by defining PATTERN_SCAN_ABORT_EN.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
`ifdef PATTERN_SCAN_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [PAT_W-1:0]  pattern,
  output logic              busy,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              match_pulse,
  output logic              done,
  output logic [CNT_W-1:0]  match_count
);

  localparam int unsigned IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  scan_state_t       state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              clr;
  logic              abort_w;

`ifdef PATTERN_SCAN_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign busy        = (state_q != IDLE);
  assign bit_valid   = (state_q == SHIFT);
  assign bit_out     = bit_valid & shreg_q[DATA_W-1];
  assign done        = (state_q == DONE);
  assign match_count = cnt_q;

  seq_match4 u_match (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .valid   (bit_valid),
    .bit_in  (bit_out),
    .pattern (pat_q),
    .match   (match_pulse)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = data_in;
          pat_d   = pattern;
          cnt_d   = '0;
          idx_d   = '0;
          clr     = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        idx_d   = idx_q + IDX_W'(1);
        // the bit presented this cycle counts even when aborting
        if (match_pulse && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        if ((idx_q == LAST_IDX) || abort_w) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed self-checking bench for pattern_scan_ctrl (default and CNT_W=3 instances).
module tb_pattern_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic [3:0]  pattern;
`ifdef PATTERN_SCAN_ABORT_EN
  logic        abort = 1'b0;
`endif

  logic       busy, bit_out, bit_valid, match_pulse, done;
  logic [4:0] match_count;
  logic       s_busy, s_bit_out, s_bit_valid, s_match_pulse, s_done;
  logic [2:0] s_match_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pattern_scan_ctrl #(.DATA_W(16), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef PATTERN_SCAN_ABORT_EN
    .abort       (abort),
`endif
    .start       (start),
    .data_in     (data_in),
    .pattern     (pattern),
    .busy        (busy),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .match_pulse (match_pulse),
    .done        (done),
    .match_count (match_count)
  );

  pattern_scan_ctrl #(.DATA_W(16), .CNT_W(3)) u_sat (
    .clk         (clk),
    .rst         (rst),
`ifdef PATTERN_SCAN_ABORT_EN
    .abort       (abort),
`endif
    .start       (start),
    .data_in     (data_in),
    .pattern     (pattern),
    .busy        (s_busy),
    .bit_out     (s_bit_out),
    .bit_valid   (s_bit_valid),
    .match_pulse (s_match_pulse),
    .done        (s_done),
    .match_count (s_match_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a job from IDLE; returns in the DONE cycle (cycle 17).
  task automatic run_job(input string tag, input logic [15:0] d, input logic [3:0] p,
                         input logic [15:0] exp_mask, input logic [4:0] exp_cnt,
                         input bit poke);
    logic [15:0] mask;
    logic [15:0] bits;
    int          extra_done;
    mask       = '0;
    bits       = '0;
    extra_done = 0;
    start   = 1'b1;
    data_in = d;
    pattern = p;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (poke && c == 5) begin
        start   = 1'b1;
        data_in = 16'hFFFF;
        pattern = 4'b1111;
      end
      if (poke && c == 6) start = 1'b0;
      mask[c-1]  = match_pulse;
      bits[16-c] = bit_out;
      if (!bit_valid || !busy || done) extra_done++;
      tick();
    end
    chk({tag, "_pulses"}, mask, exp_mask);
    chk({tag, "_bits"}, bits, d);
    chk({tag, "_shift_flags"}, extra_done, 0);
    chk({tag, "_done"}, {busy, done, bit_valid}, 3'b110);
    chk({tag, "_count"}, match_count, exp_cnt);
    if (poke) start = 1'b1;
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    pattern = '0;
    tick();
    tick();
    chk("reset_outputs", {busy, bit_out, bit_valid, match_pulse, done}, 5'b0);
    chk("reset_count", match_count, 5'd0);
    rst = 1'b0;
    tick();
    chk("idle_no_start", {busy, done}, 2'b00);

    run_job("single", 16'hD000, 4'b1101, 16'h0008, 5'd1, 1'b0);
    tick();
    chk("single_idle", {busy, done}, 2'b00);
    chk("single_held", match_count, 5'd1);

    run_job("overlap", 16'hDB6D, 4'b1101, 16'h9248, 5'd5, 1'b0);
    tick();

    run_job("ones", 16'hFFFF, 4'b1111, 16'hFFF8, 5'd13, 1'b0);
    chk("ones_sat_count", s_match_count, 3'd7);
    tick();

    // back-to-back: job 2 starts in the first IDLE cycle after DONE
    run_job("xjob1", 16'h0006, 4'b1101, 16'h0000, 5'd0, 1'b0);
    tick();
    run_job("xjob2", 16'h8000, 4'b1101, 16'h0000, 5'd0, 1'b0);
    tick();

    // start pulsed during SHIFT and DONE must be ignored
    run_job("ignore", 16'hD000, 4'b1101, 16'h0008, 5'd1, 1'b1);
    tick();
    start = 1'b0;
    chk("ignore_idle", {busy, done, bit_valid}, 3'b000);
    tick();
    tick();
    chk("ignore_still_idle", {busy, done}, 2'b00);
    chk("ignore_count_held", match_count, 5'd1);

    // reset in SHIFT cycle 8 aborts with no done
    start   = 1'b1;
    data_in = 16'hFFFF;
    pattern = 4'b1111;
    tick();
    start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    chk("rst_pre_count", match_count, 5'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_state", {busy, done, bit_valid, match_pulse}, 4'b0000);
    chk("rst_mid_count", match_count, 5'd0);
    begin
      int seen_done;
      seen_done = 0;
      for (int c = 0; c < 12; c++) begin
        tick();
        if (done || busy) seen_done++;
      end
      chk("rst_no_done", seen_done, 0);
    end

    run_job("post_rst", 16'hDB6D, 4'b1101, 16'h9248, 5'd5, 1'b0);
    tick();
    chk("post_rst_idle", {busy, done}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
Scan controller that sequences a programmable 4-bit serial pattern detector over a parallel data word. On a start command it captures a word and a target pattern, then shifts the word MSB-first through the detector, one bit per clock. It counts overlapping matches and reports completion with the final count. It sits between a register/command interface and the bit-serial detection datapath, sharing one detector across successive scan jobs.

Parameters:
DATA_W, 16, width of scanned word (bits shifted per job); legal range 4..64
CNT_W, 5, match counter width; must be >= clog2(DATA_W+1) for a non-saturating count

Ports:
clk  input  1  system clock; all logic on posedge clk
rst  input  1  synchronous, active-high reset
start  input  1  job request; accepted only in IDLE
data_in  input  DATA_W  word to scan; sampled on the accepted start
pattern  input  4  target pattern, oldest bit first (bit3 = first bit seen); sampled with data_in
busy  output  1  high from the cycle after an accepted start through the DONE cycle
bit_out  output  1  serial bit currently presented to the detector
bit_valid  output  1  high during SHIFT cycles only
match_pulse  output  1  Mealy match strobe; high in the SHIFT cycle whose bit completes the pattern
done  output  1  one-cycle completion strobe
match_count  output  CNT_W  matches found; held from DONE until the next accepted start

Behaviour:
- Clock and reset are decided: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset, sampled on the clock edge, puts the FSM in IDLE. Reset values: busy=0, bit_out=0, bit_valid=0, match_pulse=0, done=0, match_count=0. Shift register, bit counter and detector history are cleared.
- Reset asserted mid-scan aborts the job immediately. No done pulse is issued.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: when start=1, capture data_in, pattern, clear match_count and detector history; go to SHIFT. start=0 stays in IDLE.
- start is ignored in SHIFT and DONE. It is not queued.
- SHIFT:
  - bit_out = shift_reg MSB; bit_valid=1.
  - On the edge, shift left by one and increment the bit index.
  - The detector history (last 3 bits plus a fill count) updates with bit_out.
  - After the cycle with bit index DATA_W-1, go to DONE.
- Match rule:
  - match_pulse = bit_valid AND fill>=3 AND {hist[2:0], bit_out} == pattern.
  - Matches may overlap; history is not cleared on a match.
  - No match is possible in the first 3 SHIFT cycles of a job, so there are no cross-job matches.
- Counting: match_count increments on the edge ending a SHIFT cycle with match_pulse=1. It saturates at 2^CNT_W-1 with no wrap.
- DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE.
- Latency: start accepted at edge 0; SHIFT occupies cycles 1..DATA_W; done is high in cycle DATA_W+1. A back-to-back start is accepted in cycle DATA_W+2 at the earliest.

Optional Feature:
PATTERN_SCAN_ABORT_EN
- Defined: adds input `abort` (1 bit).
  - abort=1 in SHIFT goes to DONE on the next edge with the count so far. The bit presented in that cycle is still evaluated and counted.
  - abort in IDLE or DONE is ignored.
  - abort and rst together: rst wins.
- Undefined: no abort port; every job runs exactly DATA_W shift cycles.

Decomposition:
- Package pattern_scan_pkg:
  - state enum typedef scan_state_t {IDLE, SHIFT, DONE}
  - localparam PAT_W = 4
  - localparam HIST_W = PAT_W-1
- Sub-module seq_match4: programmable 4-bit Mealy matcher.
  - Inputs: clk, rst, clr, valid, bit_in, pattern.
  - Output: match.
  - Holds the 3-bit history and 2-bit fill count.
- pattern_scan_ctrl holds the FSM, shift register, bit counter and saturating counter.

Test Plan:
- Basic single match: DATA_W=16, data_in=0xD000, pattern=4'b1101, start one cycle -> match_pulse high in SHIFT cycle 4 only; done in cycle 17; match_count=1.
- Overlapping matches: data_in=0xDB6D, pattern=1101 -> 5 match_pulses at SHIFT cycles 4, 7, 10, 13, 16; match_count=5.
- All ones: data_in=0xFFFF, pattern=1111 -> match_count=13. With CNT_W=3, match_count saturates at 7.
- No cross-job match: job 1 data_in=0x0006, pattern=1101 -> count 0. Back-to-back job 2 data_in=0x8000, same pattern -> count 0.
- start pulsed during SHIFT and DONE -> ignored; exactly one done per accepted start; match_count unchanged until the next accepted start.
- rst asserted in SHIFT cycle 8 of a 0xFFFF scan -> next cycle busy=0, match_count=0, no done. A fresh start then completes normally.
